knap_search: RTL and testbench

KNAP_SEARCH -- requirements
Module: knap_search

---
 rtl/knap_search.sv | 115 +++++++++++
 tb/tb_knap_search.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/knap_search.sv
// knap_search: sweeps all 32 selections of five items (A..E) past an
// external combinational feasibility checker and keeps the highest-value
// feasible selection. Ties keep the lower-indexed selection.
// Optional macro KNAP_COUNT_EN adds a saturating count of feasible selections
// on the valid_count port; without it the port and counter do not exist.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start; results of the last sweep are held
// ST_SWEEP | cand steps 0..31, one checker evaluation per cycle
// ST_DONE  | single-cycle done pulse, then back to ST_IDLE
module knap_search #(
  parameter int VAL_W = 32,
  parameter int V0    = 4,
  parameter int V1    = 2,
  parameter int V2    = 2,
  parameter int V3    = 1,
  parameter int V4    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             valid,
  output logic [4:0]       cand,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [4:0]       best_sel,
  output logic [VAL_W-1:0] best_value
`ifdef KNAP_COUNT_EN
  ,
  output logic [5:0]       valid_count
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state;
  logic [VAL_W-1:0] cand_value;
  logic             take_cand;

  // Value of the selection on cand, wrapping at VAL_W bits.
  always_comb begin
    cand_value = '0;
    if (cand[0]) cand_value = cand_value + VAL_W'(V0);
    if (cand[1]) cand_value = cand_value + VAL_W'(V1);
    if (cand[2]) cand_value = cand_value + VAL_W'(V2);
    if (cand[3]) cand_value = cand_value + VAL_W'(V3);
    if (cand[4]) cand_value = cand_value + VAL_W'(V4);
  end

  // Strict compare: an equal-valued later selection never displaces the earlier one.
  always_comb begin
    take_cand = valid && (!found || (cand_value > best_value));
  end

  assign busy = (state == ST_SWEEP);
  assign done = (state == ST_DONE);

  // Sequencer and best-so-far tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cand       <= '0;
      found      <= 1'b0;
      best_sel   <= '0;
      best_value <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_SWEEP;
            cand       <= '0;
            found      <= 1'b0;
            best_sel   <= '0;
            best_value <= '0;
          end
        end
        ST_SWEEP: begin
          if (take_cand) begin
            found      <= 1'b1;
            best_sel   <= cand;
            best_value <= cand_value;
          end
          // cand wraps 31 -> 0 on the last evaluation.
          cand <= cand + 5'd1;
          if (cand == 5'd31) state <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          cand  <= '0;
        end
      endcase
    end
  end

`ifdef KNAP_COUNT_EN
  // Count feasible selections, saturating at 32 (the full sweep).
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_count <= '0;
    end else if ((state == ST_IDLE) && start) begin
      valid_count <= '0;
    end else if ((state == ST_SWEEP) && valid && (valid_count != 6'd32)) begin
      valid_count <= valid_count + 6'd1;
    end
  end
`endif

endmodule

// File: tb/tb_knap_search.sv
// Scoreboard bench for knap_search: stimulus pushes expected sweep results,
// a monitor pops and compares on every done pulse.
module tb_knap_search;

  localparam int VAL_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             valid;
  logic [4:0]       cand;
  logic             busy;
  logic             done;
  logic             found;
  logic [4:0]       best_sel;
  logic [VAL_W-1:0] best_value;
`ifdef KNAP_COUNT_EN
  logic [5:0]       valid_count;
`endif

  logic [31:0] mask = 32'h0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic        found;
    logic [4:0]  sel;
    int          value;
    int          count;
    int          done_cyc;
  } exp_t;

  exp_t exp_q[$];

  knap_search #(.VAL_W(VAL_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .valid      (valid),
    .cand       (cand),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .best_sel   (best_sel),
    .best_value (best_value)
`ifdef KNAP_COUNT_EN
    ,
    .valid_count(valid_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Combinational feasibility checker: a per-selection truth table.
  always_comb valid = mask[cand];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int item_value(input int c);
    int vals[5] = '{4, 2, 2, 1, 10};
    int s = 0;
    for (int i = 0; i < 5; i++) if (c[i]) s += vals[i];
    return s;
  endfunction

  // Reference: best = max value over feasible selections, lowest index among ties.
  function automatic exp_t model(input logic [31:0] m);
    exp_t e;
    int maxv = -1;
    e.found = (m != 0);
    e.sel = '0;
    e.value = 0;
    e.count = $countones(m);
    e.done_cyc = 0;
    for (int c = 0; c < 32; c++)
      if (m[c] && item_value(c) > maxv) maxv = item_value(c);
    for (int c = 31; c >= 0; c--)
      if (m[c] && item_value(c) == maxv) begin
        e.sel = 5'(c);
        e.value = maxv;
      end
    return e;
  endfunction

  function automatic logic [31:0] knap_mask();
    int wts[5] = '{12, 1, 2, 1, 4};
    logic [31:0] m = '0;
    for (int c = 0; c < 32; c++) begin
      int w = 0;
      int vol = 0;
      for (int i = 0; i < 5; i++)
        if (c[i]) begin
          w += wts[i];
          vol += 1;
        end
      m[c] = (item_value(c) >= 15) && (w <= 16) && (vol <= 10);
    end
    return m;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(e.done_cyc));
        check("found", 64'(found), 64'(e.found));
        check("best_sel", 64'(best_sel), 64'(e.sel));
        check("best_value", 64'(best_value), 64'(e.value));
`ifdef KNAP_COUNT_EN
        check("valid_count", 64'(valid_count), 64'(e.count));
`endif
        check("busy_in_done", 64'(busy), 64'd0);
      end
    end
  end

  // Pulse start from IDLE; returns the cycle number after the sampling edge.
  task automatic pulse_start(output int start_cyc);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic run_sweep(input logic [31:0] m, input exp_t e);
    int sc;
    mask = m;
    pulse_start(sc);
    check("busy_after_start", 64'(busy), 64'd1);
    e.done_cyc = sc + 32;
    exp_q.push_back(e);
    repeat (36) @(posedge clk);
    #1;
    check("idle_after_sweep", 64'({busy, done}), 64'd0);
  endtask

  task automatic wait_cand(input logic [4:0] target);
    int n = 0;
    while (cand != target && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_cand_timeout", 64'(cand), 64'(target));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cand"}, 64'(cand), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_found"}, 64'(found), 64'd0);
    check({tag, "_best_sel"}, 64'(best_sel), 64'd0);
    check({tag, "_best_value"}, 64'(best_value), 64'd0);
`ifdef KNAP_COUNT_EN
    check({tag, "_valid_count"}, 64'(valid_count), 64'd0);
`endif
  endtask

  initial begin
    exp_t e;
    int sc;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_all_zero("reset");

    // Knapsack checker: only B+C+D+E qualifies.
    e = '{found: 1'b1, sel: 5'h1E, value: 15, count: 1, done_cyc: 0};
    run_sweep(knap_mask(), e);

    e = '{found: 1'b0, sel: 5'h00, value: 0, count: 0, done_cyc: 0};
    run_sweep(32'h0, e);
    check("hold_found", 64'(found), 64'd0);

    e = '{found: 1'b1, sel: 5'h1F, value: 19, count: 32, done_cyc: 0};
    run_sweep(32'hFFFF_FFFF, e);
    check("hold_best_sel", 64'(best_sel), 64'h1F);

    // Equal-valued candidates 2 and 4: lower index wins.
    e = '{found: 1'b1, sel: 5'h02, value: 2, count: 2, done_cyc: 0};
    run_sweep(32'h0000_0014, e);

    // Start re-pulsed mid-sweep is ignored.
    mask = 32'h8421_0F0F;
    e = model(mask);
    pulse_start(sc);
    e.done_cyc = sc + 32;
    exp_q.push_back(e);
    wait_cand(5'd10);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (cyc < sc + 33) begin
      @(posedge clk);
      #1;
    end
    check("idle_34_cycles", 64'({busy, done}), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    check("no_retrigger", 64'(busy), 64'd0);

    // Reset mid-sweep: abort, no done pulse.
    mask = 32'hFFFF_FFFF;
    pulse_start(sc);
    wait_cand(5'd20);
    check("found_before_rst", 64'(found), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_all_zero("midrst");
    repeat (40) @(posedge clk);
    #1;
    check_all_zero("after_abort");
    mask = 32'h0000_0014;
    e = model(mask);
    run_sweep(mask, e);

    // Randomized feasibility tables against the reference model.
    for (int t = 0; t < 6; t++) begin
      logic [31:0] m;
      m = $urandom();
      if (t == 0) m = m & $urandom() & $urandom();
      e = model(m);
      run_sweep(m, e);
    end

    // Start held high: re-trigger straight after DONE.
    mask = 32'h0000_00F0;
    e = model(mask);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    sc = cyc + 0;
    #1;
    sc = cyc;
    e.done_cyc = sc + 32;
    exp_q.push_back(e);
    e.done_cyc = sc + 34 + 32;
    exp_q.push_back(e);
    while (cyc < sc + 35) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check("held_start_retrigger", 64'(busy), 64'd1);
    repeat (36) @(posedge clk);
    #1;

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
